// File: rtl/decoder_stage_sequencer_pkg.sv
// Shared types for the decode-stage sequencer: FSM states, SRAM grant encoding,
// the SRAM request payload and the state-to-grant mapping.
package decoder_stage_sequencer_pkg;

  localparam int unsigned ADDR_W = 18;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned CNT_W  = 24;

  localparam logic [CNT_W-1:0] WDOG_DEFAULT = 24'd4_000_000;
  localparam logic [CNT_W-1:0] RUN_MAX      = 24'hFF_FFFF;

  typedef enum logic [3:0] {
    S_SEQ_IDLE,
    S_SEQ_LAUNCH_M3,
    S_SEQ_RUN_M3,
    S_SEQ_LAUNCH_M2,
    S_SEQ_RUN_M2,
    S_SEQ_LAUNCH_M1,
    S_SEQ_RUN_M1,
    S_SEQ_FINISH,
    S_SEQ_ERROR
  } sequencer_state_type;

  typedef enum logic [1:0] {
    GRANT_NONE,
    GRANT_M3,
    GRANT_M2,
    GRANT_M1
  } grant_t;

  typedef struct packed {
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] write_data;
    logic              we_n;
  } sram_req_t;

  // Port parked: address/data zero and read, so nothing is ever written by accident.
  localparam sram_req_t SRAM_IDLE = '{address: '0, write_data: '0, we_n: 1'b1};

  // A stage owns the port in its LAUNCH and RUN states, but only if it is enabled in the mask.
  function automatic grant_t grant_of(input sequencer_state_type s, input logic [2:0] mask);
    grant_t g;
    g = GRANT_NONE;
    case (s)
      S_SEQ_LAUNCH_M3, S_SEQ_RUN_M3: g = mask[2] ? GRANT_M3 : GRANT_NONE;
      S_SEQ_LAUNCH_M2, S_SEQ_RUN_M2: g = mask[1] ? GRANT_M2 : GRANT_NONE;
      S_SEQ_LAUNCH_M1, S_SEQ_RUN_M1: g = mask[0] ? GRANT_M1 : GRANT_NONE;
      default:                       g = GRANT_NONE;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/decoder_stage_sequencer_if.sv
// Stage handshake and SRAM bus between the sequencer (master) and the stages/SRAM (slave).
interface decoder_stage_sequencer_if
  import decoder_stage_sequencer_pkg::*;
;

  logic              M3_enable;
  logic              M2_enable;
  logic              M1_enable;
  logic              M3_done;
  logic              M2_done;
  logic              M1_done;

  logic [ADDR_W-1:0] M3_SRAM_address;
  logic [ADDR_W-1:0] M2_SRAM_address;
  logic [ADDR_W-1:0] M1_SRAM_address;
  logic [DATA_W-1:0] M3_SRAM_write_data;
  logic [DATA_W-1:0] M2_SRAM_write_data;
  logic [DATA_W-1:0] M1_SRAM_write_data;
  logic              M3_SRAM_we_n;
  logic              M2_SRAM_we_n;
  logic              M1_SRAM_we_n;

  logic [ADDR_W-1:0] SRAM_address;
  logic [DATA_W-1:0] SRAM_write_data;
  logic              SRAM_we_n;

  modport master (
    output M3_enable, M2_enable, M1_enable,
    input  M3_done, M2_done, M1_done,
    input  M3_SRAM_address, M2_SRAM_address, M1_SRAM_address,
    input  M3_SRAM_write_data, M2_SRAM_write_data, M1_SRAM_write_data,
    input  M3_SRAM_we_n, M2_SRAM_we_n, M1_SRAM_we_n,
    output SRAM_address, SRAM_write_data, SRAM_we_n
  );

  modport slave (
    input  M3_enable, M2_enable, M1_enable,
    output M3_done, M2_done, M1_done,
    output M3_SRAM_address, M2_SRAM_address, M1_SRAM_address,
    output M3_SRAM_write_data, M2_SRAM_write_data, M1_SRAM_write_data,
    output M3_SRAM_we_n, M2_SRAM_we_n, M1_SRAM_we_n,
    input  SRAM_address, SRAM_write_data, SRAM_we_n
  );

endinterface

// File: rtl/decoder_stage_sequencer_sram_port_mux.sv
// 3:1 SRAM request mux driven by the registered grant; parks the port when nothing is granted.
module decoder_stage_sequencer_sram_port_mux
  import decoder_stage_sequencer_pkg::*;
(
  input  grant_t    grant,
  input  sram_req_t m3_req,
  input  sram_req_t m2_req,
  input  sram_req_t m1_req,
  output sram_req_t sram_c
);

  always_comb begin
    sram_c = SRAM_IDLE;
    case (grant)
      GRANT_M3: sram_c = m3_req;
      GRANT_M2: sram_c = m2_req;
      GRANT_M1: sram_c = m1_req;
      default:  sram_c = SRAM_IDLE;
    endcase
  end

endmodule

// File: rtl/decoder_stage_sequencer.sv
// Decompressor top-level scheduler: runs M3, M2, M1 in order, owns the SRAM port,
// and reports busy/done/error, run length and a per-stage watchdog fault.
module decoder_stage_sequencer
  import decoder_stage_sequencer_pkg::*;
#(
  parameter logic [CNT_W-1:0] WDOG_CYCLES = WDOG_DEFAULT
) (
  input  logic                      Clock,
  input  logic                      Resetn,
  input  logic                      Start,
  input  logic                      Abort,
  input  logic [2:0]                Stage_mask,
  decoder_stage_sequencer_if.master bus,
  output logic                      Busy,
  output logic                      Done,
  output logic                      Error,
  output logic [CNT_W-1:0]          Run_cycles
);

  localparam logic [CNT_W-1:0] WDOG_LAST = WDOG_CYCLES - CNT_W'(1);

  sequencer_state_type state, state_nxt;
  grant_t              grant_q, grant_nxt;
  logic [2:0]          mask_q, mask_sel;
  logic [CNT_W-1:0]    wdog_q, wdog_nxt, run_nxt;
  logic                start_accept;
  logic                en3_nxt, en2_nxt, en1_nxt;
  logic                busy_nxt, done_nxt, error_nxt;

  sram_req_t m3_req, m2_req, m1_req, sram_c;

  // State register.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) state <= S_SEQ_IDLE;
    else         state <= state_nxt;
  end

  // Next state and the values every registered output takes on the next edge.
  always_comb begin
    state_nxt    = state;
    wdog_nxt     = '0;
    start_accept = 1'b0;
    mask_sel     = (state == S_SEQ_IDLE) ? Stage_mask : mask_q;

    case (state)
      S_SEQ_IDLE: begin
        if (Start) begin
          start_accept = 1'b1;
          state_nxt    = (Stage_mask == 3'b000) ? S_SEQ_FINISH : S_SEQ_LAUNCH_M3;
        end
      end
      S_SEQ_LAUNCH_M3: state_nxt = mask_q[2] ? S_SEQ_RUN_M3 : S_SEQ_LAUNCH_M2;
      S_SEQ_RUN_M3: begin
        if (bus.M3_done)              state_nxt = S_SEQ_LAUNCH_M2;
        else if (wdog_q == WDOG_LAST) state_nxt = S_SEQ_ERROR;
        else                          wdog_nxt  = wdog_q + CNT_W'(1);
      end
      S_SEQ_LAUNCH_M2: state_nxt = mask_q[1] ? S_SEQ_RUN_M2 : S_SEQ_LAUNCH_M1;
      S_SEQ_RUN_M2: begin
        if (bus.M2_done)              state_nxt = S_SEQ_LAUNCH_M1;
        else if (wdog_q == WDOG_LAST) state_nxt = S_SEQ_ERROR;
        else                          wdog_nxt  = wdog_q + CNT_W'(1);
      end
      S_SEQ_LAUNCH_M1: state_nxt = mask_q[0] ? S_SEQ_RUN_M1 : S_SEQ_FINISH;
      S_SEQ_RUN_M1: begin
        if (bus.M1_done)              state_nxt = S_SEQ_FINISH;
        else if (wdog_q == WDOG_LAST) state_nxt = S_SEQ_ERROR;
        else                          wdog_nxt  = wdog_q + CNT_W'(1);
      end
      S_SEQ_FINISH: state_nxt = S_SEQ_IDLE;
      S_SEQ_ERROR:  state_nxt = S_SEQ_ERROR;
      default:      state_nxt = S_SEQ_IDLE;
    endcase

    // Abort overrides everything, including a Start in the same cycle.
    if (Abort) begin
      state_nxt    = S_SEQ_IDLE;
      start_accept = 1'b0;
    end

    grant_nxt = grant_of(state_nxt, mask_sel);
    en3_nxt   = (state == S_SEQ_LAUNCH_M3) && mask_q[2] && !Abort;
    en2_nxt   = (state == S_SEQ_LAUNCH_M2) && mask_q[1] && !Abort;
    en1_nxt   = (state == S_SEQ_LAUNCH_M1) && mask_q[0] && !Abort;
    busy_nxt  = !(state_nxt inside {S_SEQ_IDLE, S_SEQ_ERROR});
    done_nxt  = (state == S_SEQ_FINISH) && !Abort;
    error_nxt = (state_nxt == S_SEQ_ERROR);

    if (start_accept)                         run_nxt = '0;
    else if (Busy && (Run_cycles != RUN_MAX)) run_nxt = Run_cycles + CNT_W'(1);
    else                                      run_nxt = Run_cycles;
  end

  // Registered outputs, grant, watchdog, run counter and mask.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      grant_q       <= GRANT_NONE;
      mask_q        <= 3'b000;
      wdog_q        <= '0;
      Run_cycles    <= '0;
      Busy          <= 1'b0;
      Done          <= 1'b0;
      Error         <= 1'b0;
      bus.M3_enable <= 1'b0;
      bus.M2_enable <= 1'b0;
      bus.M1_enable <= 1'b0;
    end else begin
      grant_q       <= grant_nxt;
      wdog_q        <= wdog_nxt;
      Run_cycles    <= run_nxt;
      Busy          <= busy_nxt;
      Done          <= done_nxt;
      Error         <= error_nxt;
      bus.M3_enable <= en3_nxt;
      bus.M2_enable <= en2_nxt;
      bus.M1_enable <= en1_nxt;
      if (start_accept) mask_q <= Stage_mask;
    end
  end

  assign m3_req = '{address: bus.M3_SRAM_address, write_data: bus.M3_SRAM_write_data,
                    we_n: bus.M3_SRAM_we_n};
  assign m2_req = '{address: bus.M2_SRAM_address, write_data: bus.M2_SRAM_write_data,
                    we_n: bus.M2_SRAM_we_n};
  assign m1_req = '{address: bus.M1_SRAM_address, write_data: bus.M1_SRAM_write_data,
                    we_n: bus.M1_SRAM_we_n};

  decoder_stage_sequencer_sram_port_mux u_sram_port_mux (
    .grant  (grant_q),
    .m3_req (m3_req),
    .m2_req (m2_req),
    .m1_req (m1_req),
    .sram_c (sram_c)
  );

  assign bus.SRAM_address    = sram_c.address;
  assign bus.SRAM_write_data = sram_c.write_data;
  assign bus.SRAM_we_n       = sram_c.we_n;

endmodule

// File: tb/tb_decoder_stage_sequencer.sv
// Directed bench for decoder_stage_sequencer: vector table of full runs plus
// hand sequences for SRAM muxing, spurious inputs, abort, reset and watchdog.
module tb_decoder_stage_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, abort;
  logic [2:0]  mask;
  logic        busy, done, error;
  logic [23:0] run_cycles;
  logic [2:0]  dn;

  logic        start_w, abort_w;
  logic [2:0]  mask_w;
  logic        busy_w, done_w, error_w;
  logic [23:0] run_w;
  logic        dn_w3;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  decoder_stage_sequencer_if bus ();
  decoder_stage_sequencer_if bus_w ();

  assign bus.M3_done   = dn[0];
  assign bus.M2_done   = dn[1];
  assign bus.M1_done   = dn[2];
  assign bus_w.M3_done = dn_w3;
  assign bus_w.M2_done = 1'b0;
  assign bus_w.M1_done = 1'b0;

  decoder_stage_sequencer dut (
    .Clock(clk), .Resetn(rst_n), .Start(start), .Abort(abort), .Stage_mask(mask),
    .bus(bus), .Busy(busy), .Done(done), .Error(error), .Run_cycles(run_cycles)
  );

  decoder_stage_sequencer #(.WDOG_CYCLES(24'd16)) dut_w (
    .Clock(clk), .Resetn(rst_n), .Start(start_w), .Abort(abort_w), .Stage_mask(mask_w),
    .bus(bus_w), .Busy(busy_w), .Done(done_w), .Error(error_w), .Run_cycles(run_w)
  );

  typedef struct {
    logic [2:0] mask;
    int n3; int n2; int n1;
    int exp_run; int exp_lat;
    int en3; int en2; int en1;
  } vec_t;

  vec_t vecs [5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Each stage drives its own id as address/data and only reads.
  task automatic set_stage_defaults();
    bus.M3_SRAM_address = 18'd3; bus.M3_SRAM_write_data = 16'h0003; bus.M3_SRAM_we_n = 1'b1;
    bus.M2_SRAM_address = 18'd2; bus.M2_SRAM_write_data = 16'h0002; bus.M2_SRAM_we_n = 1'b1;
    bus.M1_SRAM_address = 18'd1; bus.M1_SRAM_write_data = 16'h0001; bus.M1_SRAM_we_n = 1'b1;
  endtask

  // One full run; stage x pulses done n_x cycles after its enable is seen.
  task automatic run_vec(input int idx);
    vec_t v; int n[3]; int c[3]; bit act[3]; int en_cnt[3];
    int last; bit order_ok; int done_cnt; int lat; int bad;
    logic [23:0] run_at_done; logic busy_at_done; logic busy1; logic [23:0] run1;
    logic [2:0] ev;
    v = vecs[idx];
    n[0] = v.n3; n[1] = v.n2; n[2] = v.n1;
    for (int i = 0; i < 3; i++) begin c[i] = 0; act[i] = 1'b0; en_cnt[i] = 0; end
    last = -1; order_ok = 1'b1; done_cnt = 0; lat = 0; bad = 0;
    run_at_done = '0; busy_at_done = 1'b1; busy1 = 1'b0; run1 = 24'hFFFFFF;
    @(negedge clk); mask = v.mask; start = 1'b1;
    for (int cyc = 1; cyc <= 200; cyc++) begin
      @(negedge clk); start = 1'b0;
      if (cyc == 1) begin busy1 = busy; run1 = run_cycles; end
      if (done) begin
        done_cnt++;
        if (lat == 0) begin lat = cyc; run_at_done = run_cycles; busy_at_done = busy; end
      end
      if (bus.SRAM_address != 18'd0 &&
          !((bus.SRAM_address == 18'd3 && v.mask[2]) ||
            (bus.SRAM_address == 18'd2 && v.mask[1]) ||
            (bus.SRAM_address == 18'd1 && v.mask[0]))) bad++;
      ev = {bus.M1_enable, bus.M2_enable, bus.M3_enable};
      dn = 3'b000;
      for (int i = 0; i < 3; i++) begin
        if (act[i]) begin
          if (c[i] == 0) begin dn[i] = 1'b1; act[i] = 1'b0; end
          else c[i]--;
        end
        if (ev[i]) begin
          en_cnt[i]++;
          if (i <= last) order_ok = 1'b0;
          last = i; act[i] = 1'b1; c[i] = n[i] - 1;
        end
      end
      if (lat != 0 && cyc >= lat + 3) break;
    end
    dn = 3'b000;
    check($sformatf("v%0d_busy_first", idx), 32'(busy1), 32'd1);
    check($sformatf("v%0d_run_first", idx), 32'(run1), 32'd0);
    check($sformatf("v%0d_done_latency", idx), 32'(lat), 32'(v.exp_lat));
    check($sformatf("v%0d_run_cycles", idx), 32'(run_at_done), 32'(v.exp_run));
    check($sformatf("v%0d_busy_at_done", idx), 32'(busy_at_done), 32'd0);
    check($sformatf("v%0d_done_count", idx), 32'(done_cnt), 32'd1);
    check($sformatf("v%0d_en3_count", idx), 32'(en_cnt[0]), 32'(v.en3));
    check($sformatf("v%0d_en2_count", idx), 32'(en_cnt[1]), 32'(v.en2));
    check($sformatf("v%0d_en1_count", idx), 32'(en_cnt[2]), 32'(v.en1));
    check($sformatf("v%0d_enable_order", idx), 32'(order_ok), 32'd1);
    check($sformatf("v%0d_bad_grant", idx), 32'(bad), 32'd0);
    check($sformatf("v%0d_run_hold", idx), 32'(run_cycles), 32'(v.exp_run));
  endtask

  initial begin
    int spur_en, bad_addr, busy_lo, late, early_err, bad_w, err_cnt, dcount, lat_w;
    logic [23:0] run_done_w;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; mask = 3'b000; dn = 3'b000;
    start_w = 1'b0; abort_w = 1'b0; mask_w = 3'b000; dn_w3 = 1'b0;
    set_stage_defaults();
    bus.M3_SRAM_we_n = 1'b0; bus.M2_SRAM_we_n = 1'b0; bus.M1_SRAM_we_n = 1'b0;
    bus_w.M3_SRAM_address = 18'h155; bus_w.M3_SRAM_write_data = 16'h5A5A; bus_w.M3_SRAM_we_n = 1'b0;
    bus_w.M2_SRAM_address = 18'h0AA; bus_w.M2_SRAM_write_data = 16'h1234; bus_w.M2_SRAM_we_n = 1'b0;
    bus_w.M1_SRAM_address = 18'h033; bus_w.M1_SRAM_write_data = 16'h4321; bus_w.M1_SRAM_we_n = 1'b0;

    vecs[0] = '{3'b111, 10, 20, 30, 67, 68, 1, 1, 1};
    vecs[1] = '{3'b001,  1,  1,  5, 10, 11, 0, 0, 1};
    vecs[2] = '{3'b000,  1,  1,  1,  1,  2, 0, 0, 0};
    vecs[3] = '{3'b101,  3,  1,  4, 13, 14, 1, 0, 1};
    vecs[4] = '{3'b010,  1,  1,  1,  6,  7, 0, 1, 0};

    // Reset values.
    #12;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    check("rst_run", 32'(run_cycles), 32'd0);
    check("rst_enables", 32'({bus.M3_enable, bus.M2_enable, bus.M1_enable}), 32'd0);
    check("rst_addr", 32'(bus.SRAM_address), 32'd0);
    check("rst_data", 32'(bus.SRAM_write_data), 32'd0);
    check("rst_we_n", 32'(bus.SRAM_we_n), 32'd1);
    check("rst_w_we_n", 32'(bus_w.SRAM_we_n), 32'd1);
    @(negedge clk); rst_n = 1'b1;
    set_stage_defaults();

    for (int i = 0; i < 5; i++) run_vec(i);

    // SRAM mux: only the granted M2 reaches the port; IDLE parks it.
    bus.M2_SRAM_address = 18'd12345; bus.M2_SRAM_write_data = 16'hABCD; bus.M2_SRAM_we_n = 1'b0;
    bus.M1_SRAM_address = 18'd7;     bus.M1_SRAM_write_data = 16'h1111; bus.M1_SRAM_we_n = 1'b0;
    @(negedge clk); mask = 3'b010; start = 1'b1;
    @(negedge clk); start = 1'b0;
    check("mux_skip3_addr", 32'(bus.SRAM_address), 32'd0);
    check("mux_skip3_we_n", 32'(bus.SRAM_we_n), 32'd1);
    @(negedge clk);
    check("mux_m2_addr", 32'(bus.SRAM_address), 32'd12345);
    check("mux_m2_data", 32'(bus.SRAM_write_data), 32'hABCD);
    check("mux_m2_we_n", 32'(bus.SRAM_we_n), 32'd0);
    @(negedge clk);
    check("mux_m2_enable", 32'(bus.M2_enable), 32'd1);
    check("mux_run_m2_addr", 32'(bus.SRAM_address), 32'd12345);
    dn = 3'b010;
    @(negedge clk); dn = 3'b000;
    check("mux_skip1_addr", 32'(bus.SRAM_address), 32'd0);
    repeat (2) @(negedge clk);
    check("mux_done", 32'(done), 32'd1);
    check("mux_idle_addr", 32'(bus.SRAM_address), 32'd0);
    check("mux_idle_data", 32'(bus.SRAM_write_data), 32'd0);
    check("mux_idle_we_n", 32'(bus.SRAM_we_n), 32'd1);
    set_stage_defaults();

    // Spurious dones and Start during RUN_M3, then Abort during RUN_M2.
    @(negedge clk); mask = 3'b111; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    check("spur_en3", 32'(bus.M3_enable), 32'd1);
    spur_en = 0; bad_addr = 0; busy_lo = 0;
    for (int k = 3; k <= 8; k++) begin
      @(negedge clk);
      spur_en += int'(bus.M3_enable) + int'(bus.M2_enable) + int'(bus.M1_enable);
      if (bus.SRAM_address != 18'd3) bad_addr++;
      if (!busy || done) busy_lo++;
      dn = 3'b000; start = 1'b0;
      if (k == 3) dn = 3'b100;
      if (k == 4) dn = 3'b010;
      if (k == 5) start = 1'b1;
      if (k == 8) dn = 3'b001;
    end
    check("spur_no_enable", 32'(spur_en), 32'd0);
    check("spur_grant_m3", 32'(bad_addr), 32'd0);
    check("spur_busy_kept", 32'(busy_lo), 32'd0);
    @(negedge clk); dn = 3'b000;
    check("spur_launch_m2_addr", 32'(bus.SRAM_address), 32'd2);
    @(negedge clk);
    check("spur_en2", 32'(bus.M2_enable), 32'd1);
    abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_addr", 32'(bus.SRAM_address), 32'd0);
    check("abort_we_n", 32'(bus.SRAM_we_n), 32'd1);
    late = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      late += int'(done) + int'(busy) + int'(bus.M3_enable) + int'(bus.M2_enable) + int'(bus.M1_enable);
      abort = (k == 0); start = (k == 0);
    end
    abort = 1'b0; start = 1'b0;
    check("abort_quiet", 32'(late), 32'd0);

    // Asynchronous reset during RUN_M2 takes effect before the next edge.
    @(negedge clk); mask = 3'b010; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rstmid_en2_before", 32'(bus.M2_enable), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rstmid_en2", 32'(bus.M2_enable), 32'd0);
    check("rstmid_busy", 32'(busy), 32'd0);
    check("rstmid_run", 32'(run_cycles), 32'd0);
    check("rstmid_addr", 32'(bus.SRAM_address), 32'd0);
    check("rstmid_we_n", 32'(bus.SRAM_we_n), 32'd1);
    @(negedge clk); rst_n = 1'b1;
    run_vec(0);

    // Watchdog (16 cycles): M3 never finishes.
    @(negedge clk); mask_w = 3'b100; start_w = 1'b1;
    early_err = 0; bad_w = 0;
    for (int cyc = 1; cyc <= 17; cyc++) begin
      @(negedge clk); start_w = 1'b0;
      if (error_w) early_err++;
      if (bus_w.SRAM_address != 18'h155 || bus_w.SRAM_we_n != 1'b0) bad_w++;
    end
    check("wdog_no_early_error", 32'(early_err), 32'd0);
    check("wdog_m3_granted", 32'(bad_w), 32'd0);
    @(negedge clk);
    check("wdog_error", 32'(error_w), 32'd1);
    check("wdog_busy", 32'(busy_w), 32'd0);
    check("wdog_we_n", 32'(bus_w.SRAM_we_n), 32'd1);
    check("wdog_addr", 32'(bus_w.SRAM_address), 32'd0);
    check("wdog_run", 32'(run_w), 32'd17);
    start_w = 1'b1;
    @(negedge clk); start_w = 1'b0;
    check("wdog_start_ignored_err", 32'(error_w), 32'd1);
    check("wdog_start_ignored_busy", 32'(busy_w), 32'd0);
    check("wdog_start_ignored_run", 32'(run_w), 32'd17);
    abort_w = 1'b1;
    @(negedge clk); abort_w = 1'b0;
    check("wdog_abort_error", 32'(error_w), 32'd0);
    check("wdog_abort_busy", 32'(busy_w), 32'd0);

    // Done arriving in the expiry cycle wins over the watchdog.
    start_w = 1'b1;
    err_cnt = 0; dcount = 0; lat_w = 0; run_done_w = '0;
    for (int cyc = 1; cyc <= 24; cyc++) begin
      @(negedge clk); start_w = 1'b0;
      if (error_w) err_cnt++;
      if (done_w) begin
        dcount++;
        if (lat_w == 0) begin lat_w = cyc; run_done_w = run_w; end
      end
      dn_w3 = (cyc == 17);
    end
    dn_w3 = 1'b0;
    check("wdog_race_no_error", 32'(err_cnt), 32'd0);
    check("wdog_race_done_count", 32'(dcount), 32'd1);
    check("wdog_race_latency", 32'(lat_w), 32'd21);
    check("wdog_race_run", 32'(run_done_w), 32'd20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
